// File: rtl/ibwt_decoder.sv
// Inverse Burrows-Wheeler decoder: loads one N-character last column,
// builds the LF table, walks it backwards and emits the recovered text.
module ibwt_decoder #(
   parameter int unsigned STRING_LEN = 8,
   parameter logic [7:0]  SENTINEL   = 8'h24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] input_string_char,
   output logic [7:0] output_string_char,
   output logic       valid_out,
   output logic       busy,
   output logic       err
);

   localparam int unsigned N  = STRING_LEN;
   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WALK, EMIT} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_d;
   logic [IW-1:0]   k, k_d;
   logic [IW-1:0]   r, r_d;
   logic [CW-1:0]   sent_cnt, sent_d;
   logic [CW-1:0]   low_cnt, low_d;
   logic            err_d, valid_d, busy_d;
   logic [7:0]      out_d;

   logic [7:0]      l_mem  [N];
   logic [IW-1:0]   lf_mem [N];
   logic [7:0]      t_mem  [N];

   logic            accept, last_char, malformed;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   lf_sum;

   assign accept    = start && ((state == IDLE) || (state == LOAD));
   assign last_char = accept && (cnt == CW'(N - 1));
   assign malformed = (sent_cnt != CW'(1)) || (low_cnt != CW'(0));
   assign idx       = IW'(cnt);

   // LF rank of L[idx]: smaller bytes anywhere plus equal bytes earlier in L
   always_comb begin
      lf_sum = '0;
      for (int unsigned j = 0; j < N; j++) begin
         if (l_mem[j] < l_mem[idx])
            lf_sum = lf_sum + CW'(1);
         else if ((l_mem[j] == l_mem[idx]) && (IW'(j) < idx))
            lf_sum = lf_sum + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         cnt                <= '0;
         k                  <= '0;
         r                  <= '0;
         sent_cnt           <= '0;
         low_cnt            <= '0;
         err                <= 1'b0;
         valid_out          <= 1'b0;
         busy               <= 1'b0;
         output_string_char <= 8'h00;
      end else begin
         state              <= state_next;
         cnt                <= cnt_d;
         k                  <= k_d;
         r                  <= r_d;
         sent_cnt           <= sent_d;
         low_cnt            <= low_d;
         err                <= err_d;
         valid_out          <= valid_d;
         busy               <= busy_d;
         output_string_char <= out_d;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = last_char ? COMPUTE : LOAD;
         LOAD:    if (last_char) state_next = COMPUTE;
         COMPUTE: begin
            if ((cnt == CW'(0)) && malformed) state_next = IDLE;
            else if (cnt == CW'(N - 1))       state_next = WALK;
         end
         WALK:    if (k == IW'(0)) state_next = EMIT;
         EMIT:    if (cnt == CW'(N)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Next values for the registered datapath and outputs
   always_comb begin
      cnt_d   = cnt;
      k_d     = k;
      r_d     = r;
      sent_d  = sent_cnt;
      low_d   = low_cnt;
      err_d   = err;
      valid_d = 1'b0;
      out_d   = output_string_char;
      busy_d  = (state_next != IDLE);
      case (state)
         IDLE, LOAD: begin
            if (accept) begin
               cnt_d = last_char ? CW'(0) : cnt + CW'(1);
               if (state == IDLE) begin
                  err_d  = 1'b0;
                  sent_d = CW'(input_string_char == SENTINEL);
                  low_d  = CW'(input_string_char < SENTINEL);
               end else begin
                  sent_d = sent_cnt + CW'(input_string_char == SENTINEL);
                  low_d  = low_cnt + CW'(input_string_char < SENTINEL);
               end
            end
         end
         COMPUTE: begin
            if ((cnt == CW'(0)) && malformed) begin
               err_d = 1'b1;
               cnt_d = '0;
            end else if (cnt == CW'(N - 1)) begin
               cnt_d = '0;
               r_d   = '0;
               k_d   = IW'(N - 2);
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         WALK: begin
            r_d = lf_mem[r];
            if (k != IW'(0)) k_d = k - IW'(1);
         end
         EMIT: begin
            if (cnt < CW'(N)) begin
               out_d   = t_mem[IW'(cnt)];
               valid_d = 1'b1;
               cnt_d   = cnt + CW'(1);
            end else begin
               cnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   // Storage arrays carry no reset; every entry is rewritten before use
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept) l_mem[idx] <= input_string_char;
         if (state == COMPUTE) begin
            lf_mem[idx]         <= IW'(lf_sum);
            t_mem[IW'(N - 1)]   <= SENTINEL;
         end
         if (state == WALK) t_mem[k] <= l_mem[r];
      end
   end

endmodule

// File: tb/tb_ibwt_decoder.sv
// Scoreboard bench for ibwt_decoder: an N=8 and an N=7 instance side by side.
`timescale 1ns/1ps
module tb_ibwt_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start7;
   logic [7:0] in8, in7;
   logic [7:0] out8, out7;
   logic       v8, v7, busy8, busy7, err8, err7;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         e0_8 = 0, e0_7 = 0;
   logic       v8_prev = 1'b0, v7_prev = 1'b0;
   byte        q8[$];
   byte        q7[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ibwt_decoder #(.STRING_LEN(8), .SENTINEL(8'h24)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .input_string_char(in8),
      .output_string_char(out8), .valid_out(v8), .busy(busy8), .err(err8));

   ibwt_decoder #(.STRING_LEN(7), .SENTINEL(8'h24)) dut7 (
      .clk(clk), .rst(rst), .start(start7), .input_string_char(in7),
      .output_string_char(out7), .valid_out(v7), .busy(busy7), .err(err7));

   // Output monitors: pop expected characters and check first-beat latency
   always @(negedge clk) begin
      if (v8) begin
         if (!v8_prev) begin
            checks++;
            if ((cyc - e0_8) !== 16) begin
               errors++;
               $display("FAIL latency8: got %0d edges, expected 16", cyc - e0_8);
            end
         end
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid8: got char %h with nothing expected", out8);
         end else begin
            byte exp8;
            exp8 = q8.pop_front();
            if (out8 !== exp8) begin
               errors++;
               $display("FAIL char8: got %h, expected %h", out8, exp8);
            end
         end
      end
      v8_prev = v8;
      if (v7) begin
         if (!v7_prev) begin
            checks++;
            if ((cyc - e0_7) !== 14) begin
               errors++;
               $display("FAIL latency7: got %0d edges, expected 14", cyc - e0_7);
            end
         end
         checks++;
         if (q7.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid7: got char %h with nothing expected", out7);
         end else begin
            byte exp7;
            exp7 = q7.pop_front();
            if (out7 !== exp7) begin
               errors++;
               $display("FAIL char7: got %h, expected %h", out7, exp7);
            end
         end
      end
      v7_prev = v7;
   end

   task automatic push8(input string s);
      for (int i = 0; i < s.len(); i++) q8.push_back(s[i]);
   endtask

   task automatic send8(input string s, input int gap_at, input int gap_len);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk); start8 = 1'b1; in8 = s[i];
         @(posedge clk);
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk); start8 = 1'b0; in8 = 8'h23;
               @(posedge clk);
            end
         end
      end
      @(negedge clk); start8 = 1'b0; e0_8 = cyc;
   endtask

   task automatic send7(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk); start7 = 1'b1; in7 = s[i];
         @(posedge clk);
      end
      @(negedge clk); start7 = 1'b0; e0_7 = cyc;
   endtask

   task automatic drain8(input string name);
      int n = 0;
      while ((busy8 || q8.size() != 0) && n < 100) begin
         @(negedge clk); n++;
      end
      checks++;
      if (busy8 !== 1'b0 || v8 !== 1'b0 || q8.size() != 0) begin
         errors++;
         $display("FAIL %s_drain8: busy=%b valid=%b pending=%0d, expected 0/0/0",
                  name, busy8, v8, q8.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start8 = 1'b1; start7 = 1'b1; in8 = 8'h24; in7 = 8'h24;
      repeat (3) @(negedge clk);
      checks++;
      if ({v8, busy8, err8, out8} !== 11'h0 || {v7, busy7, err7, out7} !== 11'h0) begin
         errors++;
         $display("FAIL reset: dut8 v/b/e/o=%b%b%b %h dut7=%b%b%b %h, expected all 0",
                  v8, busy8, err8, out8, v7, busy7, err7, out7);
      end
      start8 = 1'b0; start7 = 1'b0; rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy8 !== 1'b0 || busy7 !== 1'b0) begin
         errors++;
         $display("FAIL reset_start_ignored: busy8=%b busy7=%b, expected 0", busy8, busy7);
      end
   endtask

   task automatic test_basic();
      push8("mississ$");
      send8("ssm$ssii", -1, 0);
      drain8("basic");
      checks++;
      if (err8 !== 1'b0) begin
         errors++; $display("FAIL basic_err: got %b, expected 0", err8);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (out8 !== 8'h24) begin
         errors++; $display("FAIL hold_out: got %h, expected 24", out8);
      end
   endtask

   task automatic test_gap();
      push8("mississ$");
      send8("ssm$ssii", 3, 3);
      drain8("gap");
   endtask

   task automatic test_banana();
      int lf_exp[7] = '{1, 5, 6, 4, 0, 2, 3};
      string s = "banana$";
      for (int i = 0; i < s.len(); i++) q7.push_back(s[i]);
      send7("annb$aa");
      for (int n = 0; n < 100 && (busy7 || q7.size() != 0); n++) @(negedge clk);
      checks++;
      if (busy7 !== 1'b0 || q7.size() != 0 || err7 !== 1'b0) begin
         errors++;
         $display("FAIL banana_drain: busy=%b pending=%0d err=%b, expected 0/0/0",
                  busy7, q7.size(), err7);
      end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (int'(dut7.lf_mem[i]) !== lf_exp[i]) begin
            errors++;
            $display("FAIL lf7[%0d]: got %0d, expected %0d", i, dut7.lf_mem[i], lf_exp[i]);
         end
      end
   endtask

   task automatic test_malformed();
      send8("ssmsssii", -1, 0);
      @(negedge clk);
      checks++;
      if (err8 !== 1'b1 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL malformed_e1: err=%b busy=%b, expected 1/0", err8, busy8);
      end
      repeat (30) @(negedge clk);
      checks++;
      if (err8 !== 1'b1) begin
         errors++; $display("FAIL err_sticky: got %b, expected 1", err8);
      end
      push8("mississ$");
      send8("ssm$ssii", -1, 0);
      checks++;
      if (err8 !== 1'b0) begin
         errors++; $display("FAIL err_clear: got %b, expected 0", err8);
      end
      drain8("recover");
   endtask

   task automatic test_reset_mid();
      send8("ssm$ssii", -1, 0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy8 !== 1'b0 || v8 !== 1'b0) begin
         errors++;
         $display("FAIL midreset: busy=%b valid=%b, expected 0/0", busy8, v8);
      end
      repeat (40) @(negedge clk);
      push8("mississ$");
      send8("ssm$ssii", -1, 0);
      drain8("after_reset");
   endtask

   task automatic test_back_to_back();
      string b2 = "acc$aabb";
      int n = 0;
      push8("mississ$");
      send8("ssm$ssii", -1, 0);
      start8 = 1'b1; in8 = 8'h23;
      while (busy8 && n < 100) begin
         @(negedge clk); in8 = 8'h23; n++;
      end
      checks++;
      if (n >= 100) begin
         errors++; $display("FAIL b2b_timeout: busy stuck at %b", busy8);
      end
      push8("abcabca$");
      for (int i = 0; i < b2.len(); i++) begin
         in8 = b2[i]; start8 = 1'b1;
         @(posedge clk); @(negedge clk);
      end
      e0_8 = cyc; start8 = 1'b1; in8 = 8'h23;
      drain8("b2b");
      start8 = 1'b0;
      checks++;
      if (err8 !== 1'b0) begin
         errors++; $display("FAIL b2b_err: got %b, expected 0", err8);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_banana();
      test_malformed();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ibwt_decoder.md
IBWT_DECODER -- requirements
Module: ibwt_decoder

Interface
REQ-001 Parameter STRING_LEN, default 8, block length N in characters; legal range 2..64.
REQ-002 Parameter SENTINEL, default 8'h24 ('$'), end-of-string marker; must sort below every other legal character.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset rst, synchronous, active-high; clock clk.
REQ-005 start  input  1  qualifies input_string_char; one BWT character accepted per high cycle.
REQ-006 input_string_char  input  8  BWT (last-column) character; L[0] first.
REQ-007 output_string_char  output  8  decoded text character; registered.
REQ-008 valid_out  output  1  output_string_char valid this cycle; registered.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 err  output  1  malformed-block flag; registered.

Function
REQ-011 The FSM states SHALL be IDLE, LOAD, COMPUTE, WALK, EMIT.
REQ-012 IDLE/LOAD: each cycle with start=1 SHALL store input_string_char into L[cnt] and increment cnt; start=0 cycles SHALL hold cnt (gaps allowed).
REQ-013 The first accepted character SHALL move IDLE->LOAD and clear err.
REQ-014 The edge accepting the Nth character (E0) SHALL reset cnt to 0 and move to COMPUTE.
REQ-015 start SHALL be ignored in COMPUTE, WALK and EMIT; no character is buffered.
REQ-016 LOAD SHALL count bytes equal to SENTINEL and bytes numerically below SENTINEL.
REQ-017 Malformed block (sentinel count != 1, or any byte below SENTINEL): edge E1 SHALL set err=1 and return to IDLE; no valid_out for that block.
REQ-018 COMPUTE, edges E1..EN: edge Ei SHALL register LF[i-1] = #{j : L[j] < L[i-1]} + #{j < i-1 : L[j] == L[i-1]}, unsigned byte compare, using N parallel comparators.
REQ-019 LF entries and row pointer r SHALL be clog2(N) bits wide; LF values are always < N, no wrap.
REQ-020 Edge EN SHALL set r=0 and k=N-2, then enter WALK.
REQ-021 WALK, edges EN+1..E(2N-1): each edge SHALL write T[k]=L[r], set r=LF[r], and decrement k.
REQ-022 Edge E(2N-1) SHALL enter EMIT.
REQ-023 T[N-1] SHALL equal SENTINEL.
REQ-024 EMIT: edges E2N..E(3N-1) SHALL drive T[0]..T[N-1] in order with valid_out=1; valid_out SHALL be high for exactly N consecutive cycles, never gapped.
REQ-025 Edge E3N SHALL clear valid_out and return to IDLE; cnt and k SHALL be 0.
REQ-026 Latency: the first valid_out beat SHALL be registered at edge E2N, i.e. 2N edges after the final input character is sampled.
REQ-027 A new block SHALL be accepted from the cycle busy first reads 0.
REQ-028 start high in the same cycle as E3N SHALL be ignored, because busy is still 1 in that cycle.
REQ-029 output_string_char SHALL hold its last value when valid_out=0.
REQ-030 err SHALL stay set until reset or the next accepted character.

Reset
REQ-031 rst=1 SHALL, at the next edge, force IDLE with cnt=0, k=0, r=0, valid_out=0, output_string_char=0, err=0, busy=0.
REQ-032 rst asserted mid-LOAD/COMPUTE/WALK/EMIT SHALL abort the block: no further valid_out, partial data discarded.
REQ-033 L, LF and T storage need no reset.
REQ-034 A start with rst=1 in the same cycle SHALL be ignored.

Verification
REQ-035 N=8, start high 8 cycles with "ssm$ssii" (L[0]='s' first) -> valid_out high 8 cycles from E16 carrying "mississ$"; err=0.
REQ-036 N=8, same block with start low 3 cycles after the 4th character -> identical output; first valid_out exactly 16 edges after the last accepted character.
REQ-037 N=7 instance, "annb$aa" -> "banana$"; LF table {1,5,6,4,0,2,3}.
REQ-038 N=8, "ssmsssii" (no '$') -> err=1 at E1, busy=0 from E1, no valid_out; next good block clears err and decodes correctly.
REQ-039 rst pulsed at E5 of a good block -> no valid_out; following "ssm$ssii" decodes to "mississ$".
REQ-040 Back-to-back blocks, start held high through EMIT -> inputs ignored until busy=0; second block decodes correctly; characters presented while busy=1 are dropped.
